// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline registers: bubble constant,
// occupancy state encoding and lane indices of the D->E boundary bundle.
package pipe_pkg;

   localparam int MAX_BUS_W = 1024;

   localparam logic [MAX_BUS_W-1:0] PIPE_NOP = '0;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_t;

   localparam int LANE_IR  = 0;
   localparam int LANE_PC4 = 1;
   localparam int LANE_RS  = 2;
   localparam int LANE_RT  = 3;
   localparam int LANE_SH  = 4;
   localparam int LANE_EXT = 5;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bundle bus through one pipeline stage register; master drives
// the upstream data and the downstream ready, slave is the stage itself.
interface pipe_stage_reg_if #(
   parameter int WIDTH = 32,
   parameter int LANES = 6
);
   logic                   In_Valid;
   logic                   In_Ready;
   logic [LANES*WIDTH-1:0] In_Data;
   logic                   Out_Valid;
   logic                   Out_Ready;
   logic [LANES*WIDTH-1:0] Out_Data;

   modport master (
      output In_Valid, In_Data, Out_Ready,
      input  In_Ready, Out_Valid, Out_Data
   );

   modport slave (
      input  In_Valid, In_Data, Out_Ready,
      output In_Ready, Out_Valid, Out_Data
   );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; value visible the cycle after inc.
// No backpressure: holds at all-ones once saturated until cleared.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             inc,
   input  logic             clear,
   output logic [CNT_W-1:0] cnt
);
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled stage register (1 or 2 entries), 1-cycle latency, flush-to-bubble.
// SKID=0: In_Ready follows Out_Ready combinationally; SKID=1: In_Ready registered, one bundle absorbed.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LANES = 6,
   parameter int SKID  = 1,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Flush,
   pipe_stage_reg_if.slave  bus,
   output logic [CNT_W-1:0] Stall_Cnt
);
   localparam int BUS_W = LANES * WIDTH;

   if (BUS_W > MAX_BUS_W) begin : g_width_check
      $error("pipe_stage_reg: LANES*WIDTH = %0d exceeds %0d", BUS_W, MAX_BUS_W);
   end

   localparam logic [BUS_W-1:0] NOP = PIPE_NOP[BUS_W-1:0];

   logic             in_xfer;
   logic             out_xfer;
   logic             in_rdy;
   logic             out_vld;
   logic [BUS_W-1:0] out_dat;

   assign in_xfer  = bus.In_Valid && in_rdy;
   assign out_xfer = out_vld && bus.Out_Ready;

   if (SKID == 0) begin : g_single
      logic             main_vld_d;
      logic             main_vld_q;
      logic [BUS_W-1:0] main_dat_d;
      logic [BUS_W-1:0] main_dat_q;

      always_comb begin
         main_vld_d = main_vld_q;
         main_dat_d = main_dat_q;
         if (Flush) begin
            main_vld_d = 1'b0;
            main_dat_d = NOP;
         end else if (in_xfer) begin
            main_vld_d = 1'b1;
            main_dat_d = bus.In_Data;
         end else if (out_xfer) begin
            main_vld_d = 1'b0;
            main_dat_d = NOP;
         end
      end

      always_ff @(posedge Clk) begin
         if (!Reset_n) begin
            main_vld_q <= 1'b0;
            main_dat_q <= NOP;
         end else begin
            main_vld_q <= main_vld_d;
            main_dat_q <= main_dat_d;
         end
      end

      assign in_rdy  = !main_vld_q || bus.Out_Ready;
      assign out_vld = main_vld_q;
      assign out_dat = main_dat_q;
   end else begin : g_skid
      pipe_state_t      state_d;
      pipe_state_t      state_q;
      logic [BUS_W-1:0] main_dat_d;
      logic [BUS_W-1:0] main_dat_q;
      logic [BUS_W-1:0] skid_dat_d;
      logic [BUS_W-1:0] skid_dat_q;

      always_comb begin
         state_d    = state_q;
         main_dat_d = main_dat_q;
         skid_dat_d = skid_dat_q;
         if (Flush) begin
            state_d    = EMPTY;
            main_dat_d = NOP;
            skid_dat_d = NOP;
         end else begin
            case (state_q)
               EMPTY: begin
                  if (in_xfer) begin
                     state_d    = ONE;
                     main_dat_d = bus.In_Data;
                  end
               end
               ONE: begin
                  if (in_xfer && out_xfer) begin
                     main_dat_d = bus.In_Data;
                  end else if (in_xfer) begin
                     state_d    = TWO;
                     skid_dat_d = bus.In_Data;
                  end else if (out_xfer) begin
                     state_d    = EMPTY;
                     main_dat_d = NOP;
                  end
               end
               TWO: begin
                  // In_Ready is low here, so only the drain side can move
                  if (out_xfer) begin
                     state_d    = ONE;
                     main_dat_d = skid_dat_q;
                     skid_dat_d = NOP;
                  end
               end
               default: begin
                  state_d    = EMPTY;
                  main_dat_d = NOP;
                  skid_dat_d = NOP;
               end
            endcase
         end
      end

      always_ff @(posedge Clk) begin
         if (!Reset_n) begin
            state_q    <= EMPTY;
            main_dat_q <= NOP;
            skid_dat_q <= NOP;
         end else begin
            state_q    <= state_d;
            main_dat_q <= main_dat_d;
            skid_dat_q <= skid_dat_d;
         end
      end

      assign in_rdy  = (state_q != TWO);
      assign out_vld = (state_q != EMPTY);
      assign out_dat = main_dat_q;
   end

   assign bus.In_Ready  = in_rdy;
   assign bus.Out_Valid = out_vld;
   assign bus.Out_Data  = out_dat;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (Clk),
      .inc   (out_vld && !bus.Out_Ready),
      .clear (!Reset_n),
      .cnt   (Stall_Cnt)
   );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives three stage variants (skid, single, skid with 4-bit counter) with shared
// stimulus and checks each against a queue-occupancy model every cycle.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int WIDTH = 32;
   localparam int LANES = 6;
   localparam int BW    = WIDTH * LANES;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_vld;
   logic          out_rdy;
   logic [BW-1:0] in_dat;
   logic [15:0]   cnt1;
   logic [15:0]   cnt0;
   logic [3:0]    cnts;

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.WIDTH(WIDTH), .LANES(LANES)) if1 ();
   pipe_stage_reg_if #(.WIDTH(WIDTH), .LANES(LANES)) if0 ();
   pipe_stage_reg_if #(.WIDTH(WIDTH), .LANES(LANES)) ifs ();

   assign if1.In_Valid = in_vld;  assign if1.In_Data = in_dat;  assign if1.Out_Ready = out_rdy;
   assign if0.In_Valid = in_vld;  assign if0.In_Data = in_dat;  assign if0.Out_Ready = out_rdy;
   assign ifs.In_Valid = in_vld;  assign ifs.In_Data = in_dat;  assign ifs.Out_Ready = out_rdy;

   pipe_stage_reg #(.WIDTH(WIDTH), .LANES(LANES), .SKID(1), .CNT_W(16)) dut1 (
      .Clk(clk), .Reset_n(rst_n), .Flush(flush), .bus(if1), .Stall_Cnt(cnt1));
   pipe_stage_reg #(.WIDTH(WIDTH), .LANES(LANES), .SKID(0), .CNT_W(16)) dut0 (
      .Clk(clk), .Reset_n(rst_n), .Flush(flush), .bus(if0), .Stall_Cnt(cnt0));
   pipe_stage_reg #(.WIDTH(WIDTH), .LANES(LANES), .SKID(1), .CNT_W(4)) duts (
      .Clk(clk), .Reset_n(rst_n), .Flush(flush), .bus(ifs), .Stall_Cnt(cnts));

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model: each stage is a FIFO of capacity 1 or 2 plus a saturating counter
   int            m_skid [3] = '{1, 0, 1};
   int            m_cmax [3] = '{65535, 65535, 15};
   int            m_n    [3] = '{0, 0, 0};
   int            m_cnt  [3] = '{0, 0, 0};
   logic [BW-1:0] m_q    [3][2];

   function automatic bit m_rdy(int i);
      if (m_skid[i] != 0) return (m_n[i] < 2);
      return (m_n[i] == 0) || out_rdy;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         bit ix;
         bit ox;
         if (!rst_n) begin
            m_n[i]   = 0;
            m_cnt[i] = 0;
         end else begin
            ix = in_vld && m_rdy(i);
            ox = (m_n[i] > 0) && out_rdy;
            if ((m_n[i] > 0) && !out_rdy && (m_cnt[i] < m_cmax[i])) m_cnt[i]++;
            if (flush) begin
               m_n[i] = 0;
            end else begin
               if (ox) begin
                  m_q[i][0] = m_q[i][1];
                  m_n[i]--;
               end
               if (ix) begin
                  m_q[i][m_n[i]] = in_dat;
                  m_n[i]++;
               end
            end
         end
      end
   end

   task automatic check(string nm, logic [BW-1:0] act, logic [BW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cmp_dut(int i, logic ov, logic [BW-1:0] od, logic ir, int cnt);
      logic [BW-1:0] exp_dat;
      exp_dat = (m_n[i] > 0) ? m_q[i][0] : '0;
      check($sformatf("d%0d.out_valid", i), BW'(ov), BW'(m_n[i] > 0));
      check($sformatf("d%0d.out_data", i), od, exp_dat);
      check($sformatf("d%0d.in_ready", i), BW'(ir), BW'(m_rdy(i)));
      check($sformatf("d%0d.stall_cnt", i), BW'(cnt), BW'(m_cnt[i]));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_dut(0, if1.Out_Valid, if1.Out_Data, if1.In_Ready, int'(cnt1));
         cmp_dut(1, if0.Out_Valid, if0.Out_Data, if0.In_Ready, int'(cnt0));
         cmp_dut(2, ifs.Out_Valid, ifs.Out_Data, ifs.In_Ready, int'(cnts));
      end
   end

   function automatic logic [BW-1:0] mk(logic [31:0] l0);
      logic [BW-1:0] b;
      b = '0;
      for (int k = 0; k < LANES; k++) b[k*WIDTH +: WIDTH] = $urandom;
      b[LANE_IR*WIDTH +: WIDTH] = l0;
      return b;
   endfunction

   function automatic logic [31:0] lane0(logic [BW-1:0] b);
      return b[LANE_IR*WIDTH +: WIDTH];
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; in_dat = '0;
      step;
      step;
      rst_n = 1'b1;
      #1;
      check("rst.out_valid", BW'(if1.Out_Valid), BW'(0));
      check("rst.out_data", if1.Out_Data, '0);
      check("rst.in_ready", BW'(if1.In_Ready), BW'(1));
      check("rst.in_ready_s0", BW'(if0.In_Ready), BW'(1));
      check("rst.stall_cnt", BW'(cnt1), BW'(0));
      chk_en = 1'b1;

      // streaming, lane0 = 1..8 back-to-back
      out_rdy = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         in_vld = 1'b1; in_dat = mk(32'(k));
         step;
         check($sformatf("stream%0d.lane0", k), BW'(lane0(if1.Out_Data)), BW'(k));
         check($sformatf("stream%0d.lane0_s0", k), BW'(lane0(if0.Out_Data)), BW'(k));
      end
      in_vld = 1'b0;
      step;
      check("stream.stall_cnt", BW'(cnt1), BW'(0));

      // backpressure into the skid entry
      out_rdy = 1'b0; in_vld = 1'b1; in_dat = mk(32'hA);
      step;
      check("bp.hold_a", BW'(lane0(if1.Out_Data)), BW'(32'hA));
      in_dat = mk(32'hB);
      step;
      check("bp.skid_full_rdy", BW'(if1.In_Ready), BW'(0));
      in_dat = mk(32'hC);
      step;
      step;
      check("bp.still_a", BW'(lane0(if1.Out_Data)), BW'(32'hA));
      check("bp.stall_cnt", BW'(cnt1), BW'(3));
      out_rdy = 1'b1;
      step;
      check("bp.emit_b", BW'(lane0(if1.Out_Data)), BW'(32'hB));
      step;
      check("bp.emit_c", BW'(lane0(if1.Out_Data)), BW'(32'hC));
      in_vld = 1'b0;
      step;
      check("bp.drained", BW'(if1.Out_Valid), BW'(0));

      // flush while two bundles are held
      out_rdy = 1'b0; in_vld = 1'b1; in_dat = mk(32'hE1);
      step;
      in_dat = mk(32'hE2);
      step;
      flush = 1'b1; in_dat = mk(32'hD);
      step;
      flush = 1'b0; in_vld = 1'b0;
      check("flush.out_valid", BW'(if1.Out_Valid), BW'(0));
      check("flush.out_data", if1.Out_Data, '0);
      check("flush.in_ready", BW'(if1.In_Ready), BW'(1));
      out_rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step;
         check("flush.no_d", BW'(if1.Out_Valid), BW'(0));
      end

      // stall counter saturation on the 4-bit variant
      out_rdy = 1'b0; in_vld = 1'b1; in_dat = mk(32'h55);
      step;
      in_vld = 1'b0;
      for (int k = 0; k < 20; k++) step;
      check("sat.cnt4", BW'(cnts), BW'(15));
      check("sat.cnt16", BW'(cnt1), BW'(25));
      step;
      check("sat.hold", BW'(cnts), BW'(15));
      out_rdy = 1'b1;
      step;
      step;

      // single-register ready path
      in_vld = 1'b1; in_dat = mk(32'h71);
      step;
      out_rdy = 1'b0; in_dat = mk(32'h72);
      #1;
      check("s0.rdy_low", BW'(if0.In_Ready), BW'(0));
      step;
      check("s0.hold", BW'(lane0(if0.Out_Data)), BW'(32'h71));
      out_rdy = 1'b1;
      #1;
      check("s0.rdy_high", BW'(if0.In_Ready), BW'(1));
      step;
      check("s0.pass", BW'(lane0(if0.Out_Data)), BW'(32'h72));
      in_vld = 1'b0;
      step;

      // randomized traffic with occasional flush and reset
      for (int c = 0; c < 3000; c++) begin
         rst_n   = ($urandom_range(0, 299) != 0);
         flush   = ($urandom_range(0, 15) == 0);
         in_vld  = ($urandom_range(0, 3) != 0);
         out_rdy = ($urandom_range(0, 2) != 0);
         in_dat  = mk($urandom);
         step;
      end
      rst_n = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
      step;
      step;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register, the successor to the fixed six-field stage latches between the F/D/E/M/W stages of the five-stage MIPS core. It carries `LANES` fields of `WIDTH` bits each, and adds a valid/ready handshake, an optional two-entry skid buffer, flush-to-bubble, and a saturating stall counter. Every inter-stage boundary instantiates it, with the lane count set per boundary (six lanes for IR/PC4/RS/RT/SH/EXT at D→E).

## Interface
Parameters:
- `WIDTH`, default 32: bits per lane.
- `LANES`, default 6: number of fields carried.
- `SKID`, default 1: 0 selects a single register; 1 selects a two-entry skid buffer.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `Clk`  in  1: clock, all state updates on the rising edge.
- `Reset_n`  in  1: synchronous, active-low reset.
- `Flush`  in  1: synchronous bubble insertion (branch, jump or exception kill).
- `In_Valid`  in  1: upstream holds a valid bundle.
- `In_Ready`  out  1: stage can accept a bundle this cycle.
- `In_Data`  in  `LANES*WIDTH`: lane k occupies bits `[k*WIDTH +: WIDTH]`.
- `Out_Valid`  out  1: the output bundle is valid.
- `Out_Ready`  in  1: downstream accepts the output bundle this cycle.
- `Out_Data`  out  `LANES*WIDTH`: output bundle; all-zero (NOP bubble) whenever `Out_Valid`=0.
- `Stall_Cnt`  out  `CNT_W`: count of cycles with `Out_Valid && !Out_Ready`.

## Operation
- **Handshakes:**
  - Input transfer occurs when `In_Valid && In_Ready`.
  - Output transfer occurs when `Out_Valid && Out_Ready`.
- **SKID=0:**
  - `In_Ready = !Out_Valid || Out_Ready`, which is combinational.
  - On an input transfer, the main register loads `In_Data` and sets valid.
  - On an output transfer with no input transfer, valid clears and data goes to 0.
- **SKID=1:**
  - `In_Ready = !skid_valid`, which is registered; there is no combinational path from `Out_Ready`.
  - States are EMPTY, ONE (main valid), and TWO (main and skid valid).
  - EMPTY to ONE on an input transfer.
  - ONE stays ONE when input and output transfer together (main reloads).
  - ONE to EMPTY on an output transfer only.
  - ONE to TWO on an input transfer without an output transfer; the new bundle goes to skid.
  - TWO to ONE on an output transfer: skid moves to main, skid clears.
  - TWO cannot accept input because `In_Ready`=0.
  - Ordering is strictly FIFO: no bundle is dropped or duplicated.
- **Flush** (priority: `Reset_n`, then `Flush`, then normal):
  - All valid bits clear and all data goes to 0, and the stage returns to EMPTY.
  - An input transfer in the flush cycle counts as accepted and is discarded.
  - An output transfer in the flush cycle completes normally; downstream has already sampled it.
- **Stall counter:**
  - `Stall_Cnt` increments by 1 in each cycle where `Out_Valid && !Out_Ready`.
  - It saturates at `2^CNT_W-1`.
  - It is cleared by reset only; flush does not affect it.
- **Width rules:**
  - Lanes are opaque; no arithmetic is performed on data.
  - `LANES*WIDTH` must be at most 1024, checked by an elaboration assertion.

## Timing
- Latency is 1 cycle from an input transfer to `Out_Valid`.
- Throughput is 1 bundle per cycle while `Out_Ready`=1, in both modes.
- SKID=1 absorbs exactly one extra bundle after `Out_Ready` falls.
- `In_Ready` falls in the cycle after the skid fills.
- Reset values:
  - `Out_Valid`=0, `Out_Data`=0, `Stall_Cnt`=0, state EMPTY.
  - `In_Ready`=1 in the first cycle after reset in both modes.
- Reset mid-operation discards all held bundles on that edge.
- Flush takes effect on the edge where it is sampled. `Out_Valid`=0 in the following cycle, and `In_Ready`=1 in the following cycle.

## Structure
- Shared package `pipe_pkg` holds:
  - `PIPE_NOP` (all-zero bubble constant).
  - The state enum `pipe_state_t` {EMPTY, ONE, TWO}.
  - Lane index constants for the D→E boundary (`LANE_IR`, `LANE_PC4`, `LANE_RS`, `LANE_RT`, `LANE_SH`, `LANE_EXT`).
- One sub-module, `sat_counter` (parameter `CNT_W`; inputs inc and clear), provides `Stall_Cnt`.
- The skid and main registers stay inline under a `generate` on `SKID`.

## Test plan
- **Reset:** hold `Reset_n`=0 for 2 cycles, then release with `In_Valid`=0. Expect `Out_Valid`=0, `Out_Data`=0, `In_Ready`=1, `Stall_Cnt`=0.
- **Streaming:** `Out_Ready`=1, feed bundles with lane0 = 0x1..0x8 back-to-back. Expect lane0 0x1..0x8 on consecutive cycles one cycle later, `Stall_Cnt`=0.
- **Backpressure (SKID=1):** stream 0xA, 0xB, 0xC with `Out_Ready`=0 from cycle 1.
  - 0xA is held at the output.
  - 0xB enters skid.
  - `In_Ready`=0 and 0xC waits.
  - `Out_Ready`=1 then yields 0xA, 0xB, 0xC in order.
  - `Stall_Cnt` equals the number of stalled cycles.
- **Flush in TWO state:** assert `Flush` with `In_Valid`=1 (data 0xD). Next cycle expect `Out_Valid`=0, `Out_Data`=0, `In_Ready`=1, and 0xD is never emitted.
- **Saturation:** with `CNT_W`=4, stall for 20 cycles. Expect `Stall_Cnt`=15 and holding.
- **SKID=0:** `Out_Ready`=0 with a valid output. Expect `In_Ready`=0 in the same cycle; raising `Out_Ready` passes the next bundle one cycle later.
